// File: rtl/debug_cmd_engine.sv
// ---------------------------------------------------------------------------
// debug_cmd_engine
//
// Scan-chain command engine for a multi-channel debug port. An instruction
// and target channel are latched by ir_update. A data register is captured
// with channel status, shifted serially (LSB first out on tdo), and then
// committed by scan_update as a command to one target channel. The command is
// presented with a one-hot act_valid until that channel accepts it.
//
// Optional feature: define DEBUG_CMD_ENGINE_PARITY_EN to drop committed
// commands whose data has odd parity (flagged on err_parity). When the macro
// is undefined no parity logic exists and err_parity is tied low.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   ir_update, ir_in, ch_in   latch instruction and channel index
//   scan_capture           load sr with {pend, err_overrun, status slice}
//   scan_shift, tdi, tdo   shift sr right by one; tdo = sr[0]
//   scan_update            commit sr as a command (if length/channel valid)
//   cap_data               per-channel status words, DR_W-2 bits each
//   jdo, act_ir, act_take  committed command data, instruction, take bit
//   act_valid, act_ready   per-channel one-hot command handshake
//   err_overrun, err_len, err_parity   sticky error flags
//   dbg_state_o            FSM state (0 = IDLE, 1 = PEND)
//
// Handshake: act_valid holds one-hot on the pending channel, with jdo and
// act_ir stable, until the cycle where (act_valid & act_ready) != 0; that
// cycle completes the transfer and act_valid is low after the edge. ready
// bits of non-pending channels are ignored.
// ---------------------------------------------------------------------------
module debug_cmd_engine #(
    parameter int  DR_W   = 38,
    parameter int  IR_W   = 2,
    parameter int  NUM_CH = 3,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ir_update,
    input  logic [IR_W-1:0]              ir_in,
    input  logic [CH_W-1:0]              ch_in,
    input  logic                         scan_capture,
    input  logic                         scan_shift,
    input  logic                         scan_update,
    input  logic                         tdi,
    output logic                         tdo,
    input  logic [NUM_CH*(DR_W-2)-1:0]   cap_data,
    output logic [DR_W-1:0]              jdo,
    output logic [IR_W-1:0]              act_ir,
    output logic                         act_take,
    output logic [NUM_CH-1:0]            act_valid,
    input  logic [NUM_CH-1:0]            act_ready,
    output logic                         err_overrun,
    output logic                         err_len,
    output logic                         err_parity,
    output logic                         dbg_state_o
);

    localparam int SW      = DR_W - 2;
    localparam int CNT_W   = $clog2(DR_W + 2);
    localparam int CNT_MAX = DR_W + 1;

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [DR_W-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DR_W-1:0]     jdo_q, jdo_d;
    logic [IR_W-1:0]     act_ir_q, act_ir_d;
    logic [NUM_CH-1:0]   act_valid_q, act_valid_d;
    logic                ovr_q, ovr_d;
    logic                len_q, len_d;
`ifdef DEBUG_CMD_ENGINE_PARITY_EN
    logic                par_q, par_d;
`endif

    logic [SW-1:0]       cap_slice;
    logic                ch_ok;
    logic                upd;

    // Out-of-range channel selects an all-zero status word.
    always_comb begin
        cap_slice = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CH_W'(c)) cap_slice = cap_data[c*SW +: SW];
        end
    end

    assign ch_ok = ({1'b0, ch_q} < (CH_W+1)'(NUM_CH));
    // capture outranks update; shift is lowest.
    assign upd   = scan_update && !scan_capture;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        ir_d        = ir_q;
        ch_d        = ch_q;
        jdo_d       = jdo_q;
        act_ir_d    = act_ir_q;
        act_valid_d = act_valid_q;
        ovr_d       = ovr_q;
        len_d       = len_q;
`ifdef DEBUG_CMD_ENGINE_PARITY_EN
        par_d       = par_q;
`endif

        if (ir_update) begin
            ir_d = ir_in;
            ch_d = ch_in;
        end

        if (scan_capture) begin
            // Captured overrun bit is the value before this clear.
            sr_d  = {(state_q == PEND), ovr_q, cap_slice};
            cnt_d = '0;
            ovr_d = 1'b0;
        end else if (!scan_update && scan_shift) begin
            sr_d = {tdi, sr_q[DR_W-1:1]};
            if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (upd) begin
                    if (cnt_q != CNT_W'(DR_W)) begin
                        len_d = 1'b1;
                    end else if (!ch_ok) begin
                        // silently dropped
`ifdef DEBUG_CMD_ENGINE_PARITY_EN
                    end else if (^sr_q) begin
                        par_d = 1'b1;
`endif
                    end else begin
                        jdo_d       = sr_q;
                        act_ir_d    = ir_q;
                        act_valid_d = NUM_CH'(1) << ch_q;
                        state_d     = PEND;
                    end
                end
            end
            PEND: begin
                // An update is an overrun even in the accepting cycle.
                if (upd) ovr_d = 1'b1;
                if ((act_valid_q & act_ready) != '0) begin
                    act_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            ir_q        <= '0;
            ch_q        <= '0;
            jdo_q       <= '0;
            act_ir_q    <= '0;
            act_valid_q <= '0;
            ovr_q       <= 1'b0;
            len_q       <= 1'b0;
`ifdef DEBUG_CMD_ENGINE_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            ir_q        <= ir_d;
            ch_q        <= ch_d;
            jdo_q       <= jdo_d;
            act_ir_q    <= act_ir_d;
            act_valid_q <= act_valid_d;
            ovr_q       <= ovr_d;
            len_q       <= len_d;
`ifdef DEBUG_CMD_ENGINE_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign tdo         = sr_q[0];
    assign jdo         = jdo_q;
    assign act_ir      = act_ir_q;
    assign act_take    = jdo_q[DR_W-1];
    assign act_valid   = act_valid_q;
    assign err_overrun = ovr_q;
    assign err_len     = len_q;
    assign dbg_state_o = (state_q == PEND);
`ifdef DEBUG_CMD_ENGINE_PARITY_EN
    assign err_parity  = par_q;
`else
    assign err_parity  = 1'b0;
`endif

endmodule

// File: tb/tb_debug_cmd_engine.sv
// ---------------------------------------------------------------------------
// tb_debug_cmd_engine
//
// Directed bench for debug_cmd_engine at default parameters. Commands the
// bench expects to be accepted are pushed to exp_q when their update strobe is
// driven and popped when act_valid rises. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_debug_cmd_engine;
    localparam int DR_W   = 38;
    localparam int IR_W   = 2;
    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;
    localparam int SW     = DR_W - 2;
    localparam int EW     = NUM_CH + IR_W + DR_W;
`ifdef DEBUG_CMD_ENGINE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     ir_update = 1'b0;
    logic [IR_W-1:0]          ir_in = '0;
    logic [CH_W-1:0]          ch_in = '0;
    logic                     scan_capture = 1'b0;
    logic                     scan_shift = 1'b0;
    logic                     scan_update = 1'b0;
    logic                     tdi = 1'b0;
    logic                     tdo;
    logic [NUM_CH*SW-1:0]     cap_data = '0;
    logic [DR_W-1:0]          jdo;
    logic [IR_W-1:0]          act_ir;
    logic                     act_take;
    logic [NUM_CH-1:0]        act_valid;
    logic [NUM_CH-1:0]        act_ready = '0;
    logic                     err_overrun;
    logic                     err_len;
    logic                     err_parity;
    logic                     dbg_state_o;

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    debug_cmd_engine #(.DR_W(DR_W), .IR_W(IR_W), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .reset(reset), .ir_update(ir_update), .ir_in(ir_in),
        .ch_in(ch_in), .scan_capture(scan_capture), .scan_shift(scan_shift),
        .scan_update(scan_update), .tdi(tdi), .tdo(tdo), .cap_data(cap_data),
        .jdo(jdo), .act_ir(act_ir), .act_take(act_take), .act_valid(act_valid),
        .act_ready(act_ready), .err_overrun(err_overrun), .err_len(err_len),
        .err_parity(err_parity), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] slice(input int c);
        return cap_data[c*SW +: SW];
    endfunction

    // ---------------- drivers ----------------
    task automatic do_ir(input logic [IR_W-1:0] ir, input logic [CH_W-1:0] ch);
        ir_update = 1'b1; ir_in = ir; ch_in = ch;
        tick();
        ir_update = 1'b0;
    endtask

    task automatic do_capture();
        scan_capture = 1'b1;
        tick();
        scan_capture = 1'b0;
    endtask

    task automatic do_scan(input logic [DR_W-1:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            tdi = val[i];
            scan_shift = 1'b1;
            tick();
        end
        scan_shift = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic do_update();
        scan_update = 1'b1;
        tick();
        scan_update = 1'b0;
    endtask

    // Capture, then read every sr bit out through tdo.
    task automatic capture_read(output logic [DR_W-1:0] v);
        do_capture();
        v = '0;
        for (int i = 0; i < DR_W; i++) begin
            v[i] = tdo;
            if (i < DR_W - 1) do_scan('0, 1);
        end
    endtask

    task automatic release_ch(input int c);
        act_ready = NUM_CH'(1) << c;
        tick();
        act_ready = '0;
    endtask

    // Full command: ir, capture, 38 shifts, update. Returns whether the
    // model expects acceptance; accepted commands go on the scoreboard.
    task automatic send_cmd(input logic [IR_W-1:0] ir, input logic [CH_W-1:0] ch,
                            input logic [DR_W-1:0] val, output bit acc);
        do_ir(ir, ch);
        do_capture();
        do_scan(val, DR_W);
        acc = (int'(ch) < NUM_CH) && !(PAR_EN && (^val));
        if (acc) exp_q.push_back({NUM_CH'(1) << ch, ir, val});
        do_update();
    endtask

    // Bounded wait for a command, then compare against scoreboard head.
    task automatic check_out(input string tag);
        int waited = 0;
        logic [EW-1:0] e;
        while (act_valid == '0 && waited < 4) begin
            tick();
            waited++;
        end
        chk({tag, "_seen"}, 64'(act_valid != '0), 64'(1));
        chk({tag, "_latency"}, 64'(waited), 64'(0));
        chk({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 64'(act_valid), 64'(e[EW-1 -: NUM_CH]));
            chk({tag, "_ir"}, 64'(act_ir), 64'(e[DR_W +: IR_W]));
            chk({tag, "_jdo"}, 64'(jdo), 64'(e[DR_W-1:0]));
            chk({tag, "_take"}, 64'(act_take), 64'(e[DR_W-1]));
            chk({tag, "_state"}, 64'(dbg_state_o), 64'(1));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DR_W-1:0] v;
        logic [DR_W-1:0] v1;
        bit acc;

        cap_data = (NUM_CH*SW)'({$urandom, $urandom, $urandom, $urandom});

        // Reset
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", 64'(act_valid), 64'(0));
        chk("rst_jdo", 64'(jdo), 64'(0));
        chk("rst_ir", 64'(act_ir), 64'(0));
        chk("rst_tdo", 64'(tdo), 64'(0));
        chk("rst_take", 64'(act_take), 64'(0));
        chk("rst_errs", 64'({err_overrun, err_len, err_parity}), 64'(0));
        chk("rst_state", 64'(dbg_state_o), 64'(0));

        // Basic command to channel 1
        do_ir(2'd2, 2'd1);
        do_capture();
        chk("s1_cap_tdo", 64'(tdo), 64'(slice(1) & 1));
        do_scan(38'h2_0000_00A5, DR_W);
        acc = !(PAR_EN && (^38'h2_0000_00A5));
        if (acc) exp_q.push_back({3'b010, 2'd2, 38'h2_0000_00A5});
        do_update();
        if (acc) begin
            check_out("s1");
            act_ready = 3'b101;            // not the pending channel
            tick();
            act_ready = '0;
            chk("s1_ignore_ready", 64'(act_valid), 64'(3'b010));
            release_ch(1);
            chk("s1_released", 64'(act_valid), 64'(0));
            chk("s1_idle", 64'(dbg_state_o), 64'(0));
        end else begin
            chk("s1_par_drop", 64'(act_valid), 64'(0));
            chk("s1_par_err", 64'(err_parity), 64'(1));
        end

        // Short scan
        do_capture();
        do_scan(38'h0_0000_0003, DR_W - 1);
        do_update();
        chk("s2_valid", 64'(act_valid), 64'(0));
        chk("s2_err_len", 64'(err_len), 64'(1));
        chk("s2_state", 64'(dbg_state_o), 64'(0));

        // Overrun while channel 0 pending
        v1 = 38'h0_0000_0003;
        send_cmd(2'd1, 2'd0, v1, acc);
        check_out("s3");
        do_capture();
        do_scan(38'h0_0000_0005, DR_W);
        do_update();
        chk("s3_jdo_held", 64'(jdo), 64'(v1));
        chk("s3_valid_held", 64'(act_valid), 64'(3'b001));
        chk("s3_overrun", 64'(err_overrun), 64'(1));
        capture_read(v);
        chk("s3_cap_hi", 64'(v[DR_W-1 -: 2]), 64'(2'b11));
        chk("s3_cap_lo", 64'(v[SW-1:0]), 64'(slice(0)));
        chk("s3_ovr_cleared", 64'(err_overrun), 64'(0));
        chk("s3_len_sticky", 64'(err_len), 64'(1));
        release_ch(0);
        chk("s3_released", 64'(act_valid), 64'(0));

        // Out-of-range channel
        send_cmd(2'd0, 2'd3, 38'h0_0000_0003, acc);
        chk("s4_valid", 64'(act_valid), 64'(0));
        chk("s4_state", 64'(dbg_state_o), 64'(0));
        chk("s4_len", 64'(err_len), 64'(1));
        capture_read(v);
        chk("s4_cap_zero", 64'(v), 64'(0));

        // Update in the accepting cycle still flags overrun
        send_cmd(2'd2, 2'd2, 38'h1_0000_0001, acc);
        check_out("s6");
        do_capture();
        do_scan(38'h0_0000_0006, DR_W);
        scan_update = 1'b1;
        act_ready = 3'b100;
        tick();
        scan_update = 1'b0;
        act_ready = '0;
        chk("s6_valid", 64'(act_valid), 64'(0));
        chk("s6_state", 64'(dbg_state_o), 64'(0));
        chk("s6_overrun", 64'(err_overrun), 64'(1));
        chk("s6_jdo", 64'(jdo), 64'(38'h1_0000_0001));

        // Reset two cycles into PEND
        send_cmd(2'd3, 2'd1, 38'h3_0000_0000, acc);
        check_out("s5");
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s5_valid", 64'(act_valid), 64'(0));
        chk("s5_jdo", 64'(jdo), 64'(0));
        chk("s5_state", 64'(dbg_state_o), 64'(0));
        chk("s5_errs", 64'({err_overrun, err_len, err_parity}), 64'(0));
        act_ready = '1;
        tick();
        act_ready = '0;
        chk("s5_ready_noeffect", 64'(act_valid), 64'(0));

        // Odd-parity command
        send_cmd(2'd0, 2'd0, 38'h0_0000_0001, acc);
        if (PAR_EN) begin
            chk("par_drop", 64'(act_valid), 64'(0));
            chk("par_err", 64'(err_parity), 64'(1));
        end else begin
            check_out("par_acc");
            chk("par_err0", 64'(err_parity), 64'(0));
            release_ch(0);
        end

        // Random commands
        for (int k = 0; k < 4; k++) begin
            int c;
            c = $urandom_range(0, NUM_CH - 1);
            v = DR_W'({$urandom, $urandom});
            send_cmd(IR_W'($urandom_range(0, 3)), CH_W'(c), v, acc);
            if (acc) begin
                check_out("rnd");
                release_ch(c);
                chk("rnd_released", 64'(act_valid), 64'(0));
            end else begin
                chk("rnd_par_drop", 64'(act_valid), 64'(0));
                chk("rnd_par_err", 64'(err_parity), 64'(1));
            end
        end

        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound in case a wait stalls.
    initial begin
        #200000;
        $display("FAIL timeout simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
